result_drain: RTL
=================

Name: result_drain

Overview:
- Reader side of the systolic-array result path. The loader writes operands in through IDX/DIN/REG_SELECT; this block reads the 8x8 Y output grid back out.
- On START it snapshots all N*N tile outputs into a local buffer, then streams them one word per transfer over a VALID/READY handshake, tagged with ROW/COL.
- Sits between the systolic-array wrapper and the host-side result consumer; driven by controller.sv.

Parameters:
- N, 8, array dimension (rows = cols)
- DW, 16, result word width
- IW, $clog2(N), ROW/COL index width (derived, not overridden)

Ports:
- CLK  in  1  rising-edge clock
- RST  in  1  asynchronous, active-high reset
- EN  in  1  block enable; when low all state and counters freeze
- START  in  1  capture-and-drain request; sampled only in IDLE with EN=1
- Y_FLAT  in  N*N*DW  tile outputs; element (r,c), i.e. Y_rc, at bits [(r*N+c)*DW +: DW]
- DOUT  out  DW  current result word
- ROW  out  IW  row index of DOUT
- COL  out  IW  column index of DOUT
- VALID  out  1  DOUT/ROW/COL valid
- READY  in  1  consumer accepts the word
- LAST  out  1  high with VALID on element (N-1,N-1)
- BUSY  out  1  high in STREAM and DONE
- DONE  out  1  one-cycle pulse after the final transfer

Behaviour:
- Reset (async assert, clean release on CLK): state=IDLE, CNT=0, buffer all 0; DOUT=0, ROW=0, COL=0, VALID=0, LAST=0, BUSY=0, DONE=0.
- RST during STREAM aborts immediately; the remaining words are discarded and no DONE pulse is produced.
- States: IDLE, STREAM, FIN.
- IDLE: if EN && START at edge t:
  - copy Y_FLAT into the buffer;
  - CNT=0;
  - state=STREAM at t+1. VALID is high from t+1 with word (0,0), giving 1-cycle latency from START to first VALID.
- STREAM:
  - DOUT = buf[CNT]; ROW = CNT/N; COL = CNT%N. Order is row-major: (0,0),(0,1)..(0,N-1),(1,0)...
  - A transfer occurs on an edge where VALID && READY.
  - On a transfer with CNT < N*N-1: CNT++.
  - On a transfer with CNT == N*N-1: state=FIN.
- FIN: DONE=1 for exactly one cycle, BUSY=1, VALID=0; next state IDLE.
- VALID = (state==STREAM) && EN.
  - With EN low, VALID drops, but DOUT/ROW/COL/CNT hold.
  - Once VALID is high, DOUT/ROW/COL stay stable until accepted; the block never retracts a word except via EN or RST.
- READY low stalls indefinitely without loss. Back-to-back transfers give one word per cycle: N*N cycles minimum from first VALID to the final transfer.
- LAST = VALID && (CNT == N*N-1).
- START in STREAM or FIN is ignored; the buffer is not re-captured.
- START on the same edge that FIN returns to IDLE is ignored. A new START must be seen in IDLE, so there are 2 idle-or-fin cycles minimum between drains.
- Y_FLAT changes after capture do not affect the streamed data.
- CNT width is $clog2(N*N). It never wraps; the transfer at N*N-1 leaves CNT at N*N-1 until the next capture resets it to 0.
- All outputs are registered or decoded directly from registered state and buffer. There are no combinational paths from READY or START to any output.

Optional Feature:
- Macro: DRAIN_PARITY_EN.
- Defined:
  - adds output PAR (1 bit) = ^DOUT (even parity over the word), valid whenever VALID is high;
  - adds output PAR_ERR_CNT (8 bits), incremented on each transfer where input PAR_CHK (1 bit, driven by the consumer) != PAR;
  - PAR_ERR_CNT saturates at 255 and resets to 0 on RST.
- Undefined: PAR, PAR_CHK and PAR_ERR_CNT are absent; behaviour is otherwise identical.

Decomposition:
- Shared package sa_pkg:
  - parameters N_DIM=8 and DATA_W=16;
  - typedef word_t (logic [DATA_W-1:0]);
  - enum drain_state_t {IDLE, STREAM, FIN};
  - function flat index (r,c) -> r*N+c.
- One sub-module is natural: result_buffer, an N*N x DW register bank with a parallel capture port and an indexed read port.
- The FSM, counter and handshake stay in result_drain.

Test Plan:
- Reset/idle: RST=1 then released, no START -> VALID=0, BUSY=0, DONE=0, DOUT=0 for 20 cycles.
- Full drain:
  - stimulus: Y_rc = 16'h(r*16+c), READY=1 constant, START pulse at t;
  - required: VALID from t+1; 64 consecutive transfers in row-major order with ROW/COL matching; word 9 = (1,1) = 16'h0011;
  - required: LAST high only on (7,7)=16'h0077; DONE pulses at t+65.
- Backpressure:
  - stimulus: READY toggles 1,0,0,1 pseudo-randomly;
  - required: DOUT/ROW/COL never change while VALID && !READY; all 64 words delivered exactly once in order.
- Snapshot integrity: Y_FLAT changed to all 16'hFFFF one cycle after START, plus a second START mid-stream -> the original values stream unchanged and there is no restart.
- EN freeze:
  - stimulus: EN=0 for 5 cycles after the 10th transfer, READY=1;
  - required: VALID=0 during the freeze; on EN=1 the stream resumes at word 10 (1,2) with no skip or duplicate.
- Reset mid-stream: RST asserted after 30 transfers -> VALID/BUSY fall immediately (async), no DONE pulse; the next START drains from (0,0).

Source files
------------

// File: rtl/sa_pkg.sv
// Shared types and constants for the systolic-array result path.
package sa_pkg;

  localparam int N_DIM  = 8;
  localparam int DATA_W = 16;

  typedef logic [DATA_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FIN    = 2'd2
  } drain_state_t;

  // Row-major position of tile (r,c) in the flattened Y grid.
  function automatic int flat_idx(input int r, input int c);
    return r * N_DIM + c;
  endfunction

endpackage

// File: rtl/result_buffer.sv
// N*N x DW snapshot register bank: parallel capture of the whole Y grid, single indexed read.
// Read data is a pure decode of stored state; capture overwrites every entry in one cycle.
module result_buffer
  import sa_pkg::*;
#(
  parameter int N  = N_DIM,
  parameter int DW = DATA_W,
  localparam int CW = $clog2(N * N)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_capture,
  input  logic [N*N*DW-1:0] i_y_flat,
  input  logic [CW-1:0]     i_rd_idx,
  output logic [DW-1:0]     o_rd_dat
);

  logic [DW-1:0] r_mem [N*N];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < N * N; i++) r_mem[i] <= '0;
    end else if (i_capture) begin
      for (int i = 0; i < N * N; i++) r_mem[i] <= i_y_flat[i*DW +: DW];
    end
  end

  assign o_rd_dat = r_mem[i_rd_idx];

endmodule

// File: rtl/result_drain.sv
// Snapshots the systolic-array Y grid on START and streams it row-major over VALID/READY.
// 1-cycle START->VALID, one word per cycle; READY low stalls indefinitely. Optional DRAIN_PARITY_EN.
module result_drain
  import sa_pkg::*;
#(
  parameter int N  = N_DIM,
  parameter int DW = DATA_W,
  localparam int IW = $clog2(N),
  localparam int CW = $clog2(N * N)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic              START,
  input  logic [N*N*DW-1:0] Y_FLAT,
  output logic [DW-1:0]     DOUT,
  output logic [IW-1:0]     ROW,
  output logic [IW-1:0]     COL,
  output logic              VALID,
  input  logic              READY,
  output logic              LAST,
  output logic              BUSY,
  output logic              DONE
`ifdef DRAIN_PARITY_EN
  ,
  output logic              PAR,
  input  logic              PAR_CHK,
  output logic [7:0]        PAR_ERR_CNT
`endif
);

  localparam logic [CW-1:0] LAST_IDX = CW'(N * N - 1);

  drain_state_t  r_state;
  logic [CW-1:0] r_cnt;
  logic          w_capture;
  logic          w_xfer;
  logic [DW-1:0] w_rd_dat;

  assign w_capture = EN && START && (r_state == IDLE);
  assign w_xfer    = VALID && READY;

  result_buffer #(.N(N), .DW(DW)) u_buf (
    .i_clk     (CLK),
    .i_rst     (RST),
    .i_capture (w_capture),
    .i_y_flat  (Y_FLAT),
    .i_rd_idx  (r_cnt),
    .o_rd_dat  (w_rd_dat)
  );

  // EN low freezes state and counter; START outside IDLE is ignored.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else if (EN) begin
      case (r_state)
        IDLE: begin
          if (START) begin
            r_cnt   <= '0;
            r_state <= STREAM;
          end
        end
        STREAM: begin
          if (READY) begin
            if (r_cnt == LAST_IDX) r_state <= FIN;
            else                   r_cnt   <= r_cnt + 1'b1;
          end
        end
        FIN:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // N is a power of two, so the counter splits directly into row and column.
  assign DOUT  = w_rd_dat;
  assign ROW   = r_cnt[CW-1:IW];
  assign COL   = r_cnt[IW-1:0];
  assign VALID = (r_state == STREAM) && EN;
  assign LAST  = VALID && (r_cnt == LAST_IDX);
  assign BUSY  = (r_state == STREAM) || (r_state == FIN);
  assign DONE  = (r_state == FIN);

`ifdef DRAIN_PARITY_EN
  logic [7:0] r_par_err_cnt;

  assign PAR         = ^w_rd_dat;
  assign PAR_ERR_CNT = r_par_err_cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_par_err_cnt <= '0;
    end else if (w_xfer && (PAR_CHK != PAR) && (r_par_err_cnt != 8'hFF)) begin
      r_par_err_cnt <= r_par_err_cnt + 8'd1;
    end
  end
`endif

endmodule
